// File: rtl/int_ctrl_n.sv
// int_ctrl_n: N-channel interrupt controller for the Nano CPU io bus.
// Each external line is synchronised (s1, s2) and then delayed once more
// (s3) to detect a rising edge. The register file holds MASK, PEND, TRIG and
// ISR. The controller requests an interrupt for the highest-priority pending,
// enabled channel that outranks everything in service, and reports a vector.
//
// Ports:
//   clk     system clock, rising edge
//   rst     synchronous reset, active high
//   add     io address (register offset = add - BASE_ADD)
//   data_i  io write data
//   data_o  registered io read data (1-cycle latency, no read side effects)
//   we      io write strobe
//   eint    asynchronous external interrupt inputs
//   iack    CPU accept pulse
//   irq     interrupt request to CPU
//   irq_id  index of the highest-priority eligible channel (0 when irq=0)
//   ack     per-channel accept pulse, one cycle after the accepting edge
module int_ctrl_n #(
    parameter int                   NCH       = 8,
    parameter int                   ADD_WIDTH = 8,
    parameter logic [ADD_WIDTH-1:0] BASE_ADD  = 'h10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADD_WIDTH-1:0] add,
    input  logic [7:0]           data_i,
    output logic [7:0]           data_o,
    input  logic                 we,
    input  logic [NCH-1:0]       eint,
    input  logic                 iack,
    output logic                 irq,
    output logic [2:0]           irq_id,
    output logic [NCH-1:0]       ack
);

    typedef enum logic [2:0] {
        R_MASK = 3'd0,
        R_PEND = 3'd1,
        R_TRIG = 3'd2,
        R_ISR  = 3'd3,
        R_VEC  = 3'd4,
        R_EOI  = 3'd5,
        R_SWI  = 3'd6,
        R_RSVD = 3'd7
    } reg_e;

    logic [NCH-1:0]       s1, s2, s3;
    logic [NCH-1:0]       mask, pend, trig, isr;
    logic [NCH-1:0]       elig, acc, eoi_clr, edge_ev, w1c, swi, pend_nx;
    logic [NCH-1:0]       wdat;
    logic [ADD_WIDTH-1:0] off;
    logic                 in_map;
    reg_e                 sel;
    logic                 blocked, found;
    logic [7:0]           rd_val;

    assign off    = add - BASE_ADD;
    assign in_map = ((off >> 3) == '0);
    assign sel    = reg_e'(off[2:0]);
    assign wdat   = data_i[NCH-1:0];

    // Walking up from channel 0, the first in-service bit blocks itself and
    // every lower-priority channel, which realises "c < lowest ISR index".
    always_comb begin
        elig    = '0;
        blocked = 1'b0;
        found   = 1'b0;
        irq_id  = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (isr[c]) blocked = 1'b1;
            elig[c] = pend[c] & mask[c] & ~blocked;
        end
        for (int unsigned c = 0; c < NCH; c++) begin
            if (elig[c] && !found) begin
                irq_id = 3'(c);
                found  = 1'b1;
            end
        end
    end

    assign irq = |elig;

    assign acc     = (iack && irq) ? (NCH'(1) << irq_id) : '0;
    // isr & -isr isolates the lowest set in-service bit.
    assign eoi_clr = (we && in_map && sel == R_EOI) ? (isr & (~isr + NCH'(1))) : '0;
    assign w1c     = (we && in_map && sel == R_PEND) ? wdat : '0;
    assign swi     = (we && in_map && sel == R_SWI)  ? wdat : '0;
    assign edge_ev = s2 & ~s3;

    // Edge channels: clears (W1C, accept) lose to sets (edge event, SWI).
    // Level channels simply follow the synchronised input.
    assign pend_nx = (trig & s2) | (~trig & ((pend & ~w1c & ~acc) | edge_ev | swi));

    always_comb begin
        rd_val = '0;
        if (in_map) begin
            case (sel)
                R_MASK:  rd_val = 8'(mask);
                R_PEND:  rd_val = 8'(pend);
                R_TRIG:  rd_val = 8'(trig);
                R_ISR:   rd_val = 8'(isr);
                R_VEC:   rd_val = {irq, 4'b0000, irq_id};
                default: rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= '0;
            s2     <= '0;
            s3     <= '0;
            mask   <= '0;
            pend   <= '0;
            trig   <= '0;
            isr    <= '0;
            ack    <= '0;
            data_o <= '0;
        end else begin
            s1     <= eint;
            s2     <= s1;
            s3     <= s2;
            if (we && in_map && sel == R_MASK) mask <= wdat;
            if (we && in_map && sel == R_TRIG) trig <= wdat;
            pend   <= pend_nx;
            // EOI and accept both use pre-edge ISR, so they compose directly.
            isr    <= (isr & ~eoi_clr) | acc;
            ack    <= acc;
            data_o <= rd_val;
        end
    end

endmodule

// File: tb/tb_int_ctrl_n.sv
// Bench for int_ctrl_n: two instances (NCH=8 and NCH=3) share the io bus.
// A behavioural model predicts each post-edge output set, pushes it to a
// scoreboard queue, and a negedge monitor pops and compares.
module tb_int_ctrl_n;

    localparam logic [7:0] BASE = 8'h10;

    logic       clk = 1'b0;
    logic       rst, we, iack;
    logic [7:0] add, data_i, eint;
    logic [7:0] dout8, dout3;
    logic       irq8, irq3;
    logic [2:0] id8, id3;
    logic [7:0] ack8;
    logic [2:0] ack3;

    always #5 clk = ~clk;

    int_ctrl_n #(.NCH(8), .ADD_WIDTH(8), .BASE_ADD(8'h10)) dut8 (
        .clk(clk), .rst(rst), .add(add), .data_i(data_i), .data_o(dout8),
        .we(we), .eint(eint), .iack(iack), .irq(irq8), .irq_id(id8), .ack(ack8)
    );

    int_ctrl_n #(.NCH(3), .ADD_WIDTH(8), .BASE_ADD(8'h10)) dut3 (
        .clk(clk), .rst(rst), .add(add), .data_i(data_i), .data_o(dout3),
        .we(we), .eint(eint[2:0]), .iack(iack), .irq(irq3), .irq_id(id3), .ack(ack3)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         NCHS [2] = '{8, 3};
    logic [7:0] m_mask[2], m_pend[2], m_trig[2], m_isr[2], m_dout[2], m_ack[2];
    logic [7:0] m_h0[2], m_h1[2], m_h2[2];   // eint samples: 1, 2, 3 edges ago
    logic [7:0] n_mask[2], n_pend[2], n_trig[2], n_isr[2], n_dout[2], n_ack[2];
    logic [7:0] n_h0[2], n_h1[2], n_h2[2];

    typedef struct packed {
        logic [1:0][7:0] dout;
        logic [1:0]      irq;
        logic [1:0][2:0] id;
        logic [1:0][7:0] ack;
    } exp_t;
    exp_t sb[$];

    // Highest priority = lowest index; scanning stops at the first channel in service.
    function automatic void elig(input int i, output bit irq, output int id);
        irq = 1'b0;
        id  = 0;
        for (int c = 0; c < NCHS[i]; c++) begin
            if (m_isr[i][c]) break;
            if (m_pend[i][c] && m_mask[i][c]) begin
                irq = 1'b1;
                id  = c;
                break;
            end
        end
    endfunction

    function automatic logic [7:0] readval(input int i, input logic [7:0] off);
        bit irq;
        int id;
        elig(i, irq, id);
        case (off)
            8'd0:    return m_mask[i];
            8'd1:    return m_pend[i];
            8'd2:    return m_trig[i];
            8'd3:    return m_isr[i];
            8'd4:    return {irq, 4'b0000, 3'(id)};
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_next(input int i);
        logic [7:0] nm, off;
        bit         irq, ev, acc, p;
        int         id;
        nm  = 8'((1 << NCHS[i]) - 1);
        off = add - BASE;
        if (rst) begin
            n_mask[i] = 0; n_pend[i] = 0; n_trig[i] = 0; n_isr[i] = 0;
            n_dout[i] = 0; n_ack[i] = 0; n_h0[i] = 0; n_h1[i] = 0; n_h2[i] = 0;
            return;
        end
        elig(i, irq, id);
        n_dout[i] = readval(i, off);
        n_mask[i] = m_mask[i];
        n_trig[i] = m_trig[i];
        n_isr[i]  = m_isr[i];
        n_pend[i] = m_pend[i];
        for (int c = 0; c < NCHS[i]; c++) begin
            ev  = m_h1[i][c] && !m_h2[i][c];
            acc = iack && irq && (id == c);
            if (m_trig[i][c]) begin
                n_pend[i][c] = m_h1[i][c];
            end else begin
                p = m_pend[i][c];
                if (we && off == 8'd1 && data_i[c]) p = 1'b0;
                if (acc) p = 1'b0;
                if (ev) p = 1'b1;
                if (we && off == 8'd6 && data_i[c]) p = 1'b1;
                n_pend[i][c] = p;
            end
        end
        if (we && off == 8'd0) n_mask[i] = data_i & nm;
        if (we && off == 8'd2) n_trig[i] = data_i & nm;
        if (we && off == 8'd5) begin
            for (int c = 0; c < NCHS[i]; c++) begin
                if (m_isr[i][c]) begin
                    n_isr[i][c] = 1'b0;
                    break;
                end
            end
        end
        n_ack[i] = 8'h00;
        if (iack && irq) begin
            n_isr[i][id] = 1'b1;
            n_ack[i][id] = 1'b1;
        end
        n_h2[i] = m_h1[i];
        n_h1[i] = m_h0[i];
        n_h0[i] = eint & nm;
    endtask

    // One clock: predict from pre-edge inputs/state, commit after the edge,
    // queue the expected outputs, then step off the edge before driving.
    task automatic cyc();
        exp_t e;
        bit   irq;
        int   id;
        for (int i = 0; i < 2; i++) model_next(i);
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            m_mask[i] = n_mask[i]; m_pend[i] = n_pend[i]; m_trig[i] = n_trig[i];
            m_isr[i]  = n_isr[i];  m_dout[i] = n_dout[i]; m_ack[i]  = n_ack[i];
            m_h0[i]   = n_h0[i];   m_h1[i]   = n_h1[i];   m_h2[i]   = n_h2[i];
            elig(i, irq, id);
            e.dout[i] = m_dout[i];
            e.irq[i]  = irq;
            e.id[i]   = 3'(id);
            e.ack[i]  = m_ack[i];
        end
        sb.push_back(e);
        #1;
    endtask

    // ---------------- monitor ----------------
    exp_t me;
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            me = sb.pop_front();
            chk("dout8", dout8, me.dout[0]);
            chk("irq8", {7'b0, irq8}, {7'b0, me.irq[0]});
            chk("id8", {5'b0, id8}, {5'b0, me.id[0]});
            chk("ack8", ack8, me.ack[0]);
            chk("dout3", dout3, me.dout[1]);
            chk("irq3", {7'b0, irq3}, {7'b0, me.irq[1]});
            chk("id3", {5'b0, id3}, {5'b0, me.id[1]});
            chk("ack3", {5'b0, ack3}, me.ack[1]);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic wr(input int o, input logic [7:0] d);
        add = BASE + 8'(o); data_i = d; we = 1'b1;
        cyc();
        we = 1'b0;
    endtask

    task automatic rd(input int o, input logic [7:0] exp, input string nm);
        add = BASE + 8'(o); we = 1'b0;
        cyc();
        chk(nm, dout8, exp);
    endtask

    task automatic pulse_iack();
        iack = 1'b1;
        cyc();
        iack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; we = 1'b1; iack = 1'b0; eint = 8'hFF;
        add = BASE; data_i = 8'hFF;

        // reset with activity on every input
        idle(2);
        chk("rst_irq", {7'b0, irq8}, 8'h00);
        chk("rst_ack", ack8, 8'h00);
        chk("rst_dout", dout8, 8'h00);
        rst = 1'b0; we = 1'b0; eint = 8'h00; data_i = 8'h00;
        for (int o = 0; o < 5; o++) rd(o, 8'h00, "rst_reg");

        // edge trigger and accept
        wr(0, 8'h04);
        eint = 8'h04; cyc(); eint = 8'h00;
        idle(3);
        rd(1, 8'h04, "edge_pend");
        chk("edge_irq", {7'b0, irq8}, 8'h01);
        chk("edge_id", {5'b0, id8}, 8'h02);
        rd(4, 8'h82, "edge_vec");
        pulse_iack();
        chk("acc_ack", ack8, 8'h04);
        cyc();
        chk("acc_ack_drop", ack8, 8'h00);
        rd(1, 8'h00, "acc_pend");
        rd(3, 8'h04, "acc_isr");
        chk("acc_irq", {7'b0, irq8}, 8'h00);

        // nesting
        wr(0, 8'hFF);
        eint = 8'h20; cyc(); eint = 8'h00; idle(3);
        chk("nest_low_blocked", {7'b0, irq8}, 8'h00);
        eint = 8'h02; cyc(); eint = 8'h00; idle(3);
        chk("nest_hi_irq", {7'b0, irq8}, 8'h01);
        chk("nest_hi_id", {5'b0, id8}, 8'h01);
        pulse_iack();
        rd(3, 8'h06, "nest_isr");
        wr(5, 8'h00);
        rd(3, 8'h04, "eoi1_isr");
        wr(5, 8'h00);
        rd(3, 8'h00, "eoi2_isr");
        chk("eoi2_irq", {7'b0, irq8}, 8'h01);
        chk("eoi2_id", {5'b0, id8}, 8'h05);
        pulse_iack();
        wr(5, 8'h00);

        // level mode
        wr(2, 8'h01);
        wr(0, 8'h01);
        eint = 8'h01; idle(3);
        rd(1, 8'h01, "lvl_pend");
        pulse_iack();
        rd(1, 8'h01, "lvl_pend_iack");
        wr(1, 8'h01);
        rd(1, 8'h01, "lvl_pend_w1c");
        eint = 8'h00; idle(3);
        rd(1, 8'h00, "lvl_drop");
        wr(5, 8'h00);
        rd(3, 8'h00, "lvl_isr_clr");
        wr(2, 8'h00);

        // collisions
        eint = 8'h08; cyc(); eint = 8'h00; cyc();
        wr(1, 8'h08);                      // W1C lands with the edge event
        rd(1, 8'h08, "col_set_wins");
        wr(1, 8'h08);
        rd(1, 8'h00, "col_w1c");
        wr(6, 8'h08);
        rd(1, 8'h08, "col_swi");
        chk("col_irq_off", {7'b0, irq8}, 8'h00);
        pulse_iack();
        chk("col_iack_ack", ack8, 8'h00);
        rd(3, 8'h00, "col_iack_isr");
        rd(1, 8'h08, "col_iack_pend");

        // narrow instance and unmapped offset
        wr(0, 8'hFF);
        rd(0, 8'hFF, "mask8");
        chk("mask3", dout3, 8'h07);
        rd(7, 8'h00, "off7_8");
        chk("off7_3", dout3, 8'h00);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            rst  = ($urandom_range(0, 299) == 0);
            we   = ($urandom_range(0, 3) == 0);
            iack = ($urandom_range(0, 3) == 0);
            data_i = 8'($urandom);
            if ($urandom_range(0, 9) == 0) add = 8'($urandom);
            else add = BASE + 8'($urandom_range(0, 7));
            eint = eint ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            cyc();
        end
        rst = 1'b0; we = 1'b0; iack = 1'b0;
        idle(2);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d expected 0 queued entries", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
